// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and receiver state encoding, shared by the VGA
// timing generator and the receive-side decoder.
package vga_timing_pkg;

   localparam int VGA_H_ACTIVE    = 640;
   localparam int VGA_H_FP        = 16;
   localparam int VGA_H_SYNC      = 96;
   localparam int VGA_H_BP        = 48;
   localparam int VGA_V_ACTIVE    = 480;
   localparam int VGA_V_FP        = 10;
   localparam int VGA_V_SYNC      = 2;
   localparam int VGA_V_BP        = 33;
   localparam int VGA_LOCK_FRAMES = 2;

   localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRAIN  = 2'd1,
      LOCKED = 2'd2
   } rx_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Input register for one sync pin: normalises polarity so 1 = asserted and
// pulses rise for one cycle when the registered sync becomes asserted.
module vga_sync_edge #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sync_in,
   output logic rise
);

   logic s1_q, s1_d;
   logic prev_q, prev_d;

   always_comb begin
      s1_d   = ACTIVE_LOW ? ~sync_in : sync_in;
      prev_d = s1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         prev_q <= prev_d;
      end
   end

   assign rise = s1_q & ~prev_q;

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA receive decoder: recovers line/frame position from hsync/vsync, locks
// after LOCK_FRAMES good frames, emits pixel coordinates two clocks after the pins.
// Optional error statistics counters are built when VGA_RX_STATS_EN is defined.
module vga_rx_decoder
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE        = VGA_H_ACTIVE,
   parameter int H_FP            = VGA_H_FP,
   parameter int H_SYNC          = VGA_H_SYNC,
   parameter int H_BP            = VGA_H_BP,
   parameter int V_ACTIVE        = VGA_V_ACTIVE,
   parameter int V_FP            = VGA_V_FP,
   parameter int V_SYNC          = VGA_V_SYNC,
   parameter int V_BP            = VGA_V_BP,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int LOCK_FRAMES     = VGA_LOCK_FRAMES
) (
   input  logic        vgaclk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [3:0]  red,
   input  logic [3:0]  green,
   input  logic [3:0]  blue,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_rgb,
   output logic        frame_start,
   output logic        locked,
   output logic        line_err,
   output logic        frame_err,
   output logic [15:0] line_err_cnt,
   output logic [15:0] frame_err_cnt
);

   localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

   // S1: sync edge detection and colour capture
   logic        h_rise, v_rise;
   logic [11:0] rgb_q;

   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hsync_edge (
      .clk(vgaclk), .rst(rst), .sync_in(hsync), .rise(h_rise)
   );
   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vsync_edge (
      .clk(vgaclk), .rst(rst), .sync_in(vsync), .rise(v_rise)
   );

   always_ff @(posedge vgaclk) begin
      rgb_q <= {red, green, blue};
   end

   // hcnt_d/vcnt_d are the position of the pixel currently held in S1;
   // the _q copies therefore hold the last position of the previous line/frame.
   rx_state_t   state_q, state_d;
   logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic        vpend_q, vpend_d, line_chk_q, line_chk_d, lines_ok_q, lines_ok_d;
   logic [3:0]  good_frames_q, good_frames_d, gf_inc;
   logic        frame_bnd, line_bad, frame_bad, visible;
   logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
   logic        line_err_q, line_err_d, frame_err_q, frame_err_d;
   logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [11:0] pix_rgb_q, pix_rgb_d;

   always_comb begin
      frame_bnd = h_rise && (vpend_q || v_rise);
      line_bad  = h_rise && line_chk_q && (hcnt_q != H_LAST);
      frame_bad = frame_bnd && (vcnt_q != V_LAST);
      hcnt_d    = h_rise ? 10'd0 : sat_inc10(hcnt_q);
      vcnt_d    = vcnt_q;
      if (frame_bnd) begin
         vcnt_d = 10'd0;
      end else if (h_rise) begin
         vcnt_d = sat_inc10(vcnt_q);
      end
      vpend_d = frame_bnd ? 1'b0 : (vpend_q | v_rise);
   end

   always_comb begin
      state_d       = state_q;
      good_frames_d = good_frames_q;
      gf_inc        = good_frames_q + 4'd1;
      lines_ok_d    = lines_ok_q && !line_bad;
      line_err_d    = 1'b0;
      frame_err_d   = 1'b0;
      case (state_q)
         SEARCH: begin
            if (frame_bnd) begin
               state_d       = TRAIN;
               good_frames_d = 4'd0;
            end
         end
         TRAIN: begin
            if (frame_bnd) begin
               // The line closed by this boundary edge belongs to the frame being judged.
               if (!frame_bad && lines_ok_q && !line_bad) begin
                  good_frames_d = gf_inc;
                  if (gf_inc == LOCK_N) begin
                     state_d = LOCKED;
                  end
               end else begin
                  good_frames_d = 4'd0;
               end
            end
         end
         LOCKED: begin
            line_err_d  = line_bad;
            frame_err_d = frame_bad;
            if (line_bad || frame_bad) begin
               state_d = SEARCH;
            end
         end
         default: state_d = SEARCH;
      endcase
      if (frame_bnd) begin
         lines_ok_d = 1'b1;
      end
      // After dropping back to SEARCH the next line length is not trusted.
      if (state_d == SEARCH && state_q != SEARCH) begin
         line_chk_d = 1'b0;
      end else begin
         line_chk_d = line_chk_q | h_rise;
      end
   end

   always_comb begin
      visible = (state_q == LOCKED) &&
                (hcnt_d >= H_START) && (hcnt_d < H_END) &&
                (vcnt_d >= V_START) && (vcnt_d < V_END);
      pix_valid_d   = visible;
      pix_x_d       = visible ? (hcnt_d - H_START) : pix_x_q;
      pix_y_d       = visible ? (vcnt_d - V_START) : pix_y_q;
      pix_rgb_d     = visible ? rgb_q : pix_rgb_q;
      frame_start_d = visible && (hcnt_d == H_START) && (vcnt_d == V_START);
   end

   // S2: registered pixel outputs and error pulses
   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         state_q       <= SEARCH;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         vpend_q       <= 1'b0;
         line_chk_q    <= 1'b0;
         lines_ok_q    <= 1'b0;
         good_frames_q <= '0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_rgb_q     <= '0;
         frame_start_q <= 1'b0;
         line_err_q    <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         vpend_q       <= vpend_d;
         line_chk_q    <= line_chk_d;
         lines_ok_q    <= lines_ok_d;
         good_frames_q <= good_frames_d;
         pix_valid_q   <= pix_valid_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_rgb_q     <= pix_rgb_d;
         frame_start_q <= frame_start_d;
         line_err_q    <= line_err_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_rgb     = pix_rgb_q;
   assign frame_start = frame_start_q;
   assign locked      = (state_q == LOCKED);
   assign line_err    = line_err_q;
   assign frame_err   = frame_err_q;

`ifdef VGA_RX_STATS_EN
   logic [15:0] line_cnt_q, line_cnt_d, frame_cnt_q, frame_cnt_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      line_cnt_d  = line_err_d ? sat_inc16(line_cnt_q) : line_cnt_q;
      frame_cnt_d = frame_err_d ? sat_inc16(frame_cnt_q) : frame_cnt_q;
   end

   always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
         line_cnt_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         line_cnt_q  <= line_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign line_err_cnt  = line_cnt_q;
   assign frame_err_cnt = frame_cnt_q;
`else
   assign line_err_cnt  = 16'h0000;
   assign frame_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder using a shrunken 25x19 timing so many frames fit;
// a frame table drives lock/error scenarios and a scoreboard checks every pixel.
module tb_vga_rx_decoder;

   localparam int T_HACT = 16, T_HFP = 2, T_HSYNC = 4, T_HBP = 3;
   localparam int T_VACT = 12, T_VFP = 2, T_VSYNC = 2, T_VBP = 3;
   localparam int T_HTOT = T_HACT + T_HFP + T_HSYNC + T_HBP;
   localparam int T_VTOT = T_VACT + T_VFP + T_VSYNC + T_VBP;
   localparam int T_HSTART = T_HSYNC + T_HBP;
   localparam int T_VSTART = T_VSYNC + T_VBP;
   localparam int FULL = T_HACT * T_VACT;
   localparam int NROWS = 23;

   logic        vgaclk = 1'b0;
   logic        rst, hsync, vsync;
   logic [3:0]  red, green, blue;
   logic        pix_valid, frame_start, locked, line_err, frame_err;
   logic [9:0]  pix_x, pix_y;
   logic [11:0] pix_rgb;
   logic [15:0] line_err_cnt, frame_err_cnt;

   vga_rx_decoder #(
      .H_ACTIVE(T_HACT), .H_FP(T_HFP), .H_SYNC(T_HSYNC), .H_BP(T_HBP),
      .V_ACTIVE(T_VACT), .V_FP(T_VFP), .V_SYNC(T_VSYNC), .V_BP(T_VBP),
      .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
   ) dut (
      .vgaclk(vgaclk), .rst(rst), .hsync(hsync), .vsync(vsync),
      .red(red), .green(green), .blue(blue),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_start(frame_start), .locked(locked),
      .line_err(line_err), .frame_err(frame_err),
      .line_err_cnt(line_err_cnt), .frame_err_cnt(frame_err_cnt)
   );

   always #5 vgaclk = ~vgaclk;

   int cyc = 0;
   always @(posedge vgaclk) cyc <= cyc + 1;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] rgb;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   typedef struct packed {
      int lines;
      int bad_line;
      int bad_delta;
      int vis;
      int vis_end;
      int exp_valid;
      int exp_fs;
      int exp_le;
      int exp_fe;
      int exp_lock;
   } row_t;
   row_t rows [NROWS];

   int n_checks = 0, n_pass = 0;
   int n_valid = 0, n_fs = 0, n_le = 0, n_fe = 0, n_badpix = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every valid pixel, including latency.
   always @(negedge vgaclk) begin : mon
      exp_t e;
      if (pix_valid) begin
         n_valid++;
         if (sb.size() == 0) begin
            n_badpix++;
         end else begin
            e = sb.pop_front();
            if (e.x !== pix_x || e.y !== pix_y || e.rgb !== pix_rgb || cyc != e.cyc + 2)
               n_badpix++;
         end
      end
      if (frame_start) begin
         n_fs++;
         if (!(pix_valid && pix_x == 10'd0 && pix_y == 10'd0)) n_badpix++;
      end
      if (line_err) n_le++;
      if (frame_err) n_fe++;
   end

   task automatic drive_pix(input int l, input int c, input bit want);
      logic [9:0]  x, y;
      logic [11:0] rgb;
      bit          act;
      @(posedge vgaclk);
      #1;
      hsync = (c < T_HSYNC) ? 1'b0 : 1'b1;
      vsync = (l < T_VSYNC) ? 1'b0 : 1'b1;
      act = (c >= T_HSTART) && (c < T_HSTART + T_HACT) &&
            (l >= T_VSTART) && (l < T_VSTART + T_VACT);
      x = 10'(c - T_HSTART);
      y = 10'(l - T_VSTART);
      rgb = act ? {x[3:0], y[3:0], x[3:0] ^ y[3:0] ^ 4'h9} : 12'h000;
      {red, green, blue} = rgb;
      if (act && want) sb.push_back('{x, y, rgb, cyc});
   endtask

   task automatic drive_frame(input int nlines, input int bad_line, input int bad_delta,
                              input bit vis, input int vis_end);
      for (int l = 0; l < nlines; l++) begin
         for (int c = 0; c < T_HTOT + ((l == bad_line) ? bad_delta : 0); c++) begin
            drive_pix(l, c, vis && (l < vis_end));
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " pix_valid"}, pix_valid, 0);
      check({tag, " pix_x"}, pix_x, 0);
      check({tag, " pix_y"}, pix_y, 0);
      check({tag, " pix_rgb"}, pix_rgb, 0);
      check({tag, " frame_start"}, frame_start, 0);
      check({tag, " locked"}, locked, 0);
      check({tag, " line_err"}, line_err, 0);
      check({tag, " frame_err"}, frame_err, 0);
      check({tag, " line_err_cnt"}, line_err_cnt, 0);
      check({tag, " frame_err_cnt"}, frame_err_cnt, 0);
   endtask

   initial begin
      int s_valid, s_fs, s_le, s_fe, s_bad, tot_le, tot_fe;
      //           lines       bad  dlt vis vis_end exp_valid         fs le fe lock
      rows[0]  = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[1]  = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[2]  = '{T_VTOT,     -1,  0,  1, T_VTOT, FULL,             1, 0, 0, 1};
      rows[3]  = '{T_VTOT,     -1,  0,  1, T_VTOT, FULL,             1, 0, 0, 1};
      rows[4]  = '{T_VTOT,      7,  1,  1, 8,      (8-T_VSTART)*T_HACT, 1, 1, 0, 0};
      rows[5]  = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[6]  = '{T_VTOT,      3, -1,  0, 0,      0,                0, 0, 0, 0};
      rows[7]  = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[8]  = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[9]  = '{T_VTOT,     -1,  0,  1, T_VTOT, FULL,             1, 0, 0, 1};
      rows[10] = '{T_VTOT,     10, -1,  1, 11,     (11-T_VSTART)*T_HACT, 1, 1, 0, 0};
      rows[11] = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[12] = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[13] = '{T_VTOT,     -1,  0,  1, T_VTOT, FULL,             1, 0, 0, 1};
      rows[14] = '{T_VTOT,     16,  3,  1, 17,     FULL,             1, 1, 0, 0};
      rows[15] = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[16] = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[17] = '{T_VTOT,     -1,  0,  1, T_VTOT, FULL,             1, 0, 0, 1};
      rows[18] = '{T_VTOT - 1, -1,  0,  1, T_VTOT, FULL,             1, 0, 0, 1};
      rows[19] = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 1, 0};
      rows[20] = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[21] = '{T_VTOT,     -1,  0,  0, 0,      0,                0, 0, 0, 0};
      rows[22] = '{T_VTOT,     -1,  0,  1, T_VTOT, FULL,             1, 0, 0, 1};

      rst = 1'b1;
      hsync = 1'b1;
      vsync = 1'b1;
      {red, green, blue} = 12'h000;
      repeat (3) @(posedge vgaclk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;

      tot_le = 0;
      tot_fe = 0;
      for (int i = 0; i < NROWS; i++) begin
         s_valid = n_valid; s_fs = n_fs; s_le = n_le; s_fe = n_fe; s_bad = n_badpix;
         drive_frame(rows[i].lines, rows[i].bad_line, rows[i].bad_delta,
                     rows[i].vis != 0, rows[i].vis_end);
         check($sformatf("row%0d valid_count", i), n_valid - s_valid, rows[i].exp_valid);
         check($sformatf("row%0d frame_start_count", i), n_fs - s_fs, rows[i].exp_fs);
         check($sformatf("row%0d line_err_pulses", i), n_le - s_le, rows[i].exp_le);
         check($sformatf("row%0d frame_err_pulses", i), n_fe - s_fe, rows[i].exp_fe);
         check($sformatf("row%0d pixel_mismatches", i), n_badpix - s_bad, 0);
         check($sformatf("row%0d locked", i), locked, rows[i].exp_lock);
         check($sformatf("row%0d leftover_expected", i), sb.size(), 0);
         sb.delete();
         tot_le += rows[i].exp_le;
         tot_fe += rows[i].exp_fe;
      end

`ifdef VGA_RX_STATS_EN
      check("stats line_err_cnt", line_err_cnt, tot_le);
      check("stats frame_err_cnt", frame_err_cnt, tot_fe);
`else
      check("stats line_err_cnt tied", line_err_cnt, 0);
      check("stats frame_err_cnt tied", frame_err_cnt, 0);
`endif

      // Reset asserted mid-frame while pixel (8,6) sits on the outputs.
      s_bad = n_badpix;
      for (int l = 0; l <= T_VSTART + 6; l++) begin
         for (int c = 0; c < T_HTOT; c++) begin
            if (l == T_VSTART + 6 && c > T_HSTART + 8 + 2) break;
            drive_pix(l, c, 1'b1);
         end
      end
      check("midframe pix_valid", pix_valid, 1);
      check("midframe pix_x", pix_x, 8);
      check("midframe pix_y", pix_y, 6);
      check("midframe pixel_mismatches", n_badpix - s_bad, 0);
      rst = 1'b1;
      #1;
      check_outputs_zero("async_reset");
      sb.delete();
      hsync = 1'b1;
      vsync = 1'b1;
      repeat (3) @(posedge vgaclk);
      #1;
      rst = 1'b0;

      for (int f = 0; f < 3; f++) begin
         s_valid = n_valid; s_fs = n_fs; s_bad = n_badpix;
         drive_frame(T_VTOT, -1, 0, f == 2, T_VTOT);
         check($sformatf("relock f%0d valid_count", f), n_valid - s_valid, (f == 2) ? FULL : 0);
         check($sformatf("relock f%0d frame_start_count", f), n_fs - s_fs, (f == 2) ? 1 : 0);
         check($sformatf("relock f%0d pixel_mismatches", f), n_badpix - s_bad, 0);
         check($sformatf("relock f%0d locked", f), locked, (f == 2) ? 1 : 0);
      end
      check("relock leftover_expected", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_rx_decoder.md
Name: vga_rx_decoder

Overview:
Receive-side counterpart of the VGA timing generator. Samples hsync/vsync/RGB on the pixel clock, recovers line and frame position, and locks after consecutive well-formed frames. Reports per-pixel coordinates and colour for loopback checking of generator output. Sits beside the generator on the same vgaclk domain, on the output pins or inside the test harness.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses are low-active
LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
vgaclk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
hsync  in  1  horizontal sync from generator
vsync  in  1  vertical sync from generator
red  in  4  red channel
green  in  4  green channel
blue  in  4  blue channel
pix_valid  out  1  pixel outputs are a visible pixel
pix_x  out  10  column 0..H_ACTIVE-1
pix_y  out  10  row 0..V_ACTIVE-1
pix_rgb  out  12  {red,green,blue}
frame_start  out  1  one-cycle pulse on pixel (0,0)
locked  out  1  decoder in LOCKED state
line_err  out  1  one-cycle pulse: bad line length while LOCKED
frame_err  out  1  one-cycle pulse: bad frame length while LOCKED
line_err_cnt  out  16  saturating count (stats feature)
frame_err_cnt  out  16  saturating count (stats feature)

Behaviour:
- Derived: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525); H_START = H_SYNC+H_BP; V_START = V_SYNC+V_BP.
- All inputs registered once (stage S1); polarity normalised so 1 = sync asserted. Edge = S1 asserted, previous S1 deasserted.
- hcnt (10b): 0 on hsync edge cycle; otherwise +1, saturating at 1023.
- Line length = hcnt+1 at the hsync edge; good iff == H_TOTAL. The first edge after reset/SEARCH entry is not checked.
- vsync edge sets vpend. At the next hsync edge (same cycle counts): vcnt = 0, vpend cleared, frame length checked. Other hsync edges: vcnt+1, saturating at 1023.
- Frame length = vcnt+1 at that edge; good iff == V_TOTAL.
- FSM:
  - SEARCH: on first frame boundary -> TRAIN with good_frames = 0.
  - TRAIN: at frame boundary, previous frame good and all its lines good -> good_frames+1, else good_frames = 0. When good_frames reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: any bad line pulses line_err; any bad frame pulses frame_err; either -> SEARCH. Both in the same cycle pulse both.
- visible = LOCKED && H_START <= hcnt < H_START+H_ACTIVE && V_START <= vcnt < V_START+V_ACTIVE.
- Output stage S2 registers pix_valid, pix_x = hcnt-H_START, pix_y = vcnt-V_START, pix_rgb.
- pix_x/pix_y/pix_rgb hold last value when pix_valid = 0.
- frame_start = pix_valid && x == 0 && y == 0.
- Latency: pins to pix_* = 2 vgaclk.
- Reset (async, any state, mid-frame included): FSM = SEARCH; hcnt, vcnt = 0; vpend = 0; all outputs and counters 0. On exit, resumes from SEARCH.

Optional Feature:
VGA_RX_STATS_EN:
- Defined: line_err_cnt/frame_err_cnt increment on each line_err/frame_err pulse, saturate at 16'hFFFF, clear only on rst.
- Undefined: no counter logic; both ports tied to 0.

Decomposition:
- Package vga_timing_pkg: 640x480 timing constants, H_TOTAL/V_TOTAL, rx_state_t enum {SEARCH, TRAIN, LOCKED}. Shared with the generator.
- Sub-module vga_sync_edge: S1 register, polarity normalisation, edge pulse. Instanced for hsync and vsync.

Test Plan:
- Drive nominal 800x525 timing, 3 frames -> locked rises at second frame boundary after first; frame_start once per frame; 307200 pix_valid cycles per frame.
- Ramp red = x[3:0] -> pix_rgb[11:8] == pix_x[3:0] on every valid pixel; pix_x 0..639, pix_y 0..479, 2-cycle latency.
- While locked, one line of 801 clocks -> one line_err pulse; locked falls; relock after LOCK_FRAMES+1 good frames.
- While locked, frame of 524 lines -> frame_err pulse, state SEARCH, pix_valid = 0 until relock.
- Assert rst at pixel (320,240) -> all outputs 0 in that cycle; after release, lock reacquired normally.
- With VGA_RX_STATS_EN, inject 3 bad lines -> line_err_cnt == 3. Without the macro -> counter ports read 0.
